// File: rtl/sd_cmd_controller.sv
// SD CMD-line transaction sequencer: builds the 48-bit command frame with
// CRC7, drives the CMD serializer, optionally waits for and captures a
// 48-bit response through the deserializer, and checks its framing and CRC.
module sd_cmd_controller #(
  parameter int FRAME_BITS   = 48,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                  iClock_SD,
  input  logic                  iReset,
  input  logic                  iStart,
  input  logic [5:0]            iCmdIndex,
  input  logic [31:0]           iArgument,
  input  logic                  iExpectResp,
  input  logic                  iCheckCrc,
  output logic [FRAME_BITS-1:0] oTxParallel,
  output logic                  oTxEnable,
  input  logic                  iTxComplete,
  input  logic                  iCmdLine,
  output logic                  oRxEnable,
  input  logic [FRAME_BITS-1:0] iRxParallel,
  input  logic                  iRxComplete,
  output logic [FRAME_BITS-1:0] oResponse,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oTimeout,
  output logic                  oRespError
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TX    = 3'd2,
    S_WAIT  = 3'd3,
    S_RX    = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // CRC7 (x^7 + x^3 + 1, seed 0) over the 40 leading frame bits, MSB first.
  function automatic logic [6:0] crc7_40(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) begin
        crc = crc ^ 7'h09;
      end else begin
        crc = crc;
      end
    end
    return crc;
  endfunction

  // The converters index bit 0 as the first bit on the wire.
  function automatic logic [FRAME_BITS-1:0] bit_reverse(input logic [FRAME_BITS-1:0] v);
    logic [FRAME_BITS-1:0] r;
    for (int i = 0; i < FRAME_BITS; i++) begin
      r[i] = v[FRAME_BITS-1-i];
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [5:0]            cmd_index_q, cmd_index_d;
  logic [31:0]           argument_q, argument_d;
  logic                  expect_resp_q, expect_resp_d;
  logic                  check_crc_q, check_crc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] tx_parallel_q, tx_parallel_d;
  logic [FRAME_BITS-1:0] response_q, response_d;
  logic                  tx_enable_q, tx_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  resp_error_q, resp_error_d;
  logic                  rx_enable_s;
  logic [39:0]           cmd_head_s;

  assign cmd_head_s = {1'b0, 1'b1, cmd_index_q, argument_q};

  // Next-state, datapath updates and the Mealy deserializer enable.
  always_comb begin
    state_d       = state_q;
    cmd_index_d   = cmd_index_q;
    argument_d    = argument_q;
    expect_resp_d = expect_resp_q;
    check_crc_d   = check_crc_q;
    cnt_d         = {CNT_W{1'b0}};
    tx_parallel_d = tx_parallel_q;
    response_d    = response_q;
    timeout_d     = timeout_q;
    resp_error_d  = resp_error_q;
    rx_enable_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          cmd_index_d   = iCmdIndex;
          argument_d    = iArgument;
          expect_resp_d = iExpectResp;
          check_crc_d   = iCheckCrc;
          timeout_d     = 1'b0;
          resp_error_d  = 1'b0;
          response_d    = {FRAME_BITS{1'b0}};
          state_d       = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tx_parallel_d = bit_reverse({cmd_head_s, crc7_40(cmd_head_s), 1'b1});
        state_d       = S_TX;
      end
      S_TX: begin
        if (iTxComplete) begin
          state_d = expect_resp_q ? S_WAIT : S_DONE;
        end else begin
          state_d = S_TX;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A start bit on the last allowed cycle still beats the timeout.
        if (!iCmdLine) begin
          rx_enable_s = 1'b1;
          state_d     = S_RX;
        end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RX: begin
        rx_enable_s = 1'b1;
        if (iRxComplete) begin
          response_d = bit_reverse(iRxParallel);
          state_d    = S_CHECK;
        end else begin
          state_d = S_RX;
        end
      end
      S_CHECK: begin
        resp_error_d = response_q[47] | response_q[46] | ~response_q[0] |
                       (check_crc_q & (crc7_40(response_q[47:8]) != response_q[7:1]));
        state_d      = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    tx_enable_d = (state_q == S_TX) && (state_d == S_TX);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClock_SD) begin
    if (!iReset) begin
      state_q       <= S_IDLE;
      cmd_index_q   <= 6'd0;
      argument_q    <= 32'd0;
      expect_resp_q <= 1'b0;
      check_crc_q   <= 1'b0;
      cnt_q         <= {CNT_W{1'b0}};
      tx_parallel_q <= {FRAME_BITS{1'b1}};
      response_q    <= {FRAME_BITS{1'b0}};
      tx_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      resp_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_index_q   <= cmd_index_d;
      argument_q    <= argument_d;
      expect_resp_q <= expect_resp_d;
      check_crc_q   <= check_crc_d;
      cnt_q         <= cnt_d;
      tx_parallel_q <= tx_parallel_d;
      response_q    <= response_d;
      tx_enable_q   <= tx_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      resp_error_q  <= resp_error_d;
    end
  end

  assign oTxParallel = tx_parallel_q;
  assign oTxEnable   = tx_enable_q;
  assign oRxEnable   = rx_enable_s;
  assign oResponse   = response_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oTimeout    = timeout_q;
  assign oRespError  = resp_error_q;

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Self-checking bench for sd_cmd_controller: directed SD commands plus
// randomized transactions compared against a frame-level reference model.
module tb_sd_cmd_controller;

  logic        iClock_SD = 1'b0;
  logic        iReset    = 1'b0;
  logic        iStart    = 1'b0;
  logic [5:0]  iCmdIndex = 6'd0;
  logic [31:0] iArgument = 32'd0;
  logic        iExpectResp = 1'b0;
  logic        iCheckCrc   = 1'b0;
  logic [47:0] oTxParallel;
  logic        oTxEnable;
  logic        iTxComplete = 1'b0;
  logic        iCmdLine    = 1'b1;
  logic        oRxEnable;
  logic [47:0] iRxParallel = 48'd0;
  logic        iRxComplete = 1'b0;
  logic [47:0] oResponse;
  logic        oBusy;
  logic        oDone;
  logic        oTimeout;
  logic        oRespError;

  int tests_run = 0;
  int tests_failed = 0;

  sd_cmd_controller dut (
    .iClock_SD  (iClock_SD),
    .iReset     (iReset),
    .iStart     (iStart),
    .iCmdIndex  (iCmdIndex),
    .iArgument  (iArgument),
    .iExpectResp(iExpectResp),
    .iCheckCrc  (iCheckCrc),
    .oTxParallel(oTxParallel),
    .oTxEnable  (oTxEnable),
    .iTxComplete(iTxComplete),
    .iCmdLine   (iCmdLine),
    .oRxEnable  (oRxEnable),
    .iRxParallel(iRxParallel),
    .iRxComplete(iRxComplete),
    .oResponse  (oResponse),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oTimeout   (oTimeout),
    .oRespError (oRespError)
  );

  always #5 iClock_SD = ~iClock_SD;

  // Reference CRC7: remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc_model(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int b = 46; b >= 7; b--) begin
      if (r[b]) r[b -: 8] = r[b -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] rev(input logic [47:0] v);
    return {<<{v}};
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, crc_model(head), 1'b1};
  endfunction

  function automatic logic resp_err_model(input logic [47:0] r, input logic chk);
    logic bad;
    bad = (r[47] != 1'b0) || (r[46] != 1'b0) || (r[0] != 1'b1);
    if (chk && (crc_model(r[47:8]) != r[7:1])) bad = 1'b1;
    return bad;
  endfunction

  task automatic step();
    @(posedge iClock_SD);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction. delay < 0 means no start bit (timeout path).
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                        input logic exp_r, input logic chk_crc,
                        input logic [47:0] exp_frame, input logic [47:0] resp,
                        input logic exp_err, input int delay, input logic inject);
    int  tx_wait;
    int  rx_wait;
    logic early;
    iCmdIndex = idx; iArgument = arg; iExpectResp = exp_r; iCheckCrc = chk_crc;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    iCmdIndex = ~idx; iArgument = ~arg;
    check("busy_after_start", {47'd0, oBusy}, 48'd1);
    check("txen_in_load", {47'd0, oTxEnable}, 48'd0);
    step();
    check("tx_frame", oTxParallel, rev(exp_frame));
    check("txen_first_tx", {47'd0, oTxEnable}, 48'd0);
    step();
    check("txen_high", {47'd0, oTxEnable}, 48'd1);
    tx_wait = $urandom_range(0, 4);
    if (inject) begin
      iStart = 1'b1;
      step();
      iStart = 1'b0;
    end
    for (int k = 0; k < tx_wait; k++) step();
    iTxComplete = 1'b1;
    step();
    iTxComplete = 1'b0;
    check("txen_drop", {47'd0, oTxEnable}, 48'd0);
    if (!exp_r) begin
      check("done_noresp", {47'd0, oDone}, 48'd1);
      check("rxen_noresp", {47'd0, oRxEnable}, 48'd0);
    end else if (delay < 0) begin
      early = 1'b0;
      for (int k = 1; k < 64; k++) begin
        if (inject && k == 1) iStart = 1'b1;
        step();
        iStart = 1'b0;
        if (oDone !== 1'b0 || oRxEnable !== 1'b0 || oBusy !== 1'b1) early = 1'b1;
      end
      check("wait_quiet", {47'd0, early}, 48'd0);
      step();
      check("timeout_done", {47'd0, oDone}, 48'd1);
      check("timeout_flag", {47'd0, oTimeout}, 48'd1);
    end else begin
      for (int k = 0; k < delay; k++) begin
        if (inject && k == 0) iStart = 1'b1;
        step();
        iStart = 1'b0;
      end
      check("rxen_before_start", {47'd0, oRxEnable}, 48'd0);
      iCmdLine = 1'b0;
      #1;
      check("rxen_mealy", {47'd0, oRxEnable}, 48'd1);
      step();
      iCmdLine = 1'b1;
      check("rxen_rx", {47'd0, oRxEnable}, 48'd1);
      check("no_timeout_rx", {47'd0, oTimeout}, 48'd0);
      rx_wait = $urandom_range(0, 3);
      for (int k = 0; k < rx_wait; k++) step();
      iRxParallel = rev(resp);
      iRxComplete = 1'b1;
      step();
      iRxComplete = 1'b0;
      iRxParallel = $urandom();
      check("response", oResponse, resp);
      step();
      check("resp_done", {47'd0, oDone}, 48'd1);
      check("resp_error", {47'd0, oRespError}, {47'd0, exp_err});
      check("resp_timeout", {47'd0, oTimeout}, 48'd0);
    end
    step();
    check("done_one_cycle", {47'd0, oDone}, 48'd0);
    check("idle_busy", {47'd0, oBusy}, 48'd0);
    check("frame_hold", oTxParallel, rev(exp_frame));
    if (exp_r && delay >= 0) check("response_hold", oResponse, resp);
    step();
    check("no_extra_done", {47'd0, oDone}, 48'd0);
  endtask

  logic [5:0]  r_idx;
  logic [31:0] r_arg;
  logic        r_exp, r_chk;
  logic [47:0] r_resp;
  logic [39:0] r_head;
  int          r_delay;
  int          kind;

  initial begin
    // Reset state
    iReset = 1'b0;
    step();
    step();
    iReset = 1'b1;
    check("rst_txpar", oTxParallel, 48'hFFFF_FFFF_FFFF);
    check("rst_txen", {47'd0, oTxEnable}, 48'd0);
    check("rst_rxen", {47'd0, oRxEnable}, 48'd0);
    check("rst_busy", {47'd0, oBusy}, 48'd0);
    check("rst_done", {47'd0, oDone}, 48'd0);
    check("rst_timeout", {47'd0, oTimeout}, 48'd0);
    check("rst_resperr", {47'd0, oRespError}, 48'd0);
    check("rst_response", oResponse, 48'd0);
    step();

    // CMD0, no response
    do_cmd(6'd0, 32'd0, 1'b0, 1'b0, 48'h40_0000_0000_95, 48'd0, 1'b0, 0, 1'b0);
    // CMD8 with good R7 response
    do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_13, 1'b0, 3, 1'b0);
    // Timeout
    do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87, 48'd0, 1'b0, -1, 1'b0);
    // Start bit on the final allowed cycle
    do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_13, 1'b0, 63, 1'b0);
    // Response faults
    do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_11, 1'b1, 0, 1'b0);
    do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_12, 1'b1, 5, 1'b0);
    do_cmd(6'd8, 32'h1AA, 1'b1, 1'b0, 48'h48_0000_01AA_87, 48'h08_0000_01AA_11, 1'b0, 2, 1'b0);
    // iStart pulses during TX and WAIT_RESP are ignored
    do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_13, 1'b0, 4, 1'b1);
    do_cmd(6'd0, 32'd0, 1'b0, 1'b0, 48'h40_0000_0000_95, 48'd0, 1'b0, 0, 1'b1);

    // Reset mid-TX
    iCmdIndex = 6'd17; iArgument = 32'hDEAD_BEEF; iExpectResp = 1'b1; iCheckCrc = 1'b1;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    step();
    step();
    check("midtx_txen", {47'd0, oTxEnable}, 48'd1);
    iReset = 1'b0;
    step();
    iReset = 1'b1;
    check("midrst_txen", {47'd0, oTxEnable}, 48'd0);
    check("midrst_txpar", oTxParallel, 48'hFFFF_FFFF_FFFF);
    check("midrst_busy", {47'd0, oBusy}, 48'd0);
    step();
    check("midrst_stay_idle", {47'd0, oBusy}, 48'd0);
    do_cmd(6'd0, 32'd0, 1'b0, 1'b0, 48'h40_0000_0000_95, 48'd0, 1'b0, 0, 1'b0);

    // Randomized transactions against the model
    for (int t = 0; t < 10; t++) begin
      r_idx = 6'($urandom());
      r_arg = $urandom();
      r_exp = 1'($urandom_range(0, 3) != 0);
      r_chk = 1'($urandom_range(0, 1));
      r_head = {2'b00, 6'($urandom()), 32'($urandom())};
      r_resp = {r_head, crc_model(r_head), 1'b1};
      kind = $urandom_range(0, 3);
      if (kind == 1) r_resp[$urandom_range(1, 7)] ^= 1'b1;
      if (kind == 2) r_resp[0] = 1'b0;
      if (kind == 3) r_resp[46] = 1'b1;
      r_delay = $urandom_range(0, 75);
      if (r_delay > 63) r_delay = -1;
      do_cmd(r_idx, r_arg, r_exp, r_chk, cmd_frame(r_idx, r_arg), r_resp,
             resp_err_model(r_resp, r_chk), r_delay, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
